// File: rtl/debounce_channel.sv
// Single-channel input conditioner: 2-flop synchroniser, tick-driven stability
// counter, debounced level, one-cycle edge pulses and a sticky event flag.
module debounce_channel #(
    parameter int unsigned STABLE_TICKS = 5,
    parameter logic        RESET_LEVEL  = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pad_i,
    input  logic tick_i,
    input  logic event_clr_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_o
);

    localparam int unsigned     CntW    = $clog2(STABLE_TICKS + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_TICKS - 1);

    logic            sync_meta_q, sync_meta_d;
    logic            sync_q, sync_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            rise_q, rise_d;
    logic            fall_q, fall_d;
    logic            event_q, event_d;

    // Next-state: synchroniser shift, stability count on ticks, sticky event
    always_comb begin
        sync_meta_d = pad_i;
        sync_d      = sync_meta_q;
        cnt_d       = cnt_q;
        level_d     = level_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        // A pulse visible this cycle sets the flag even if a clear arrives with it
        event_d     = (event_q & ~event_clr_i) | rise_q | fall_q;
        if (tick_i) begin
            if (sync_q == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                level_d = sync_q;
                cnt_d   = '0;
                rise_d  = sync_q;
                fall_d  = ~sync_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers; reset leaves level at the idle pad value so no edge is seen
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_meta_q <= RESET_LEVEL;
            sync_q      <= RESET_LEVEL;
            cnt_q       <= '0;
            level_q     <= RESET_LEVEL;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            event_q     <= 1'b0;
        end else begin
            sync_meta_q <= sync_meta_d;
            sync_q      <= sync_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            event_q     <= event_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign event_o = event_q;

endmodule

// File: rtl/gpio_key_debounce.sv
// GPIO key conditioner: shared sample-tick prescaler feeding WIDTH independent
// debounce channels, plus the masked interrupt reduction.
module gpio_key_debounce #(
    parameter int unsigned     WIDTH        = 8,
    parameter int unsigned     TICK_DIV     = 24000,
    parameter int unsigned     STABLE_TICKS = 5,
    parameter logic [WIDTH-1:0] RESET_LEVEL = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pad_i,
    input  logic [WIDTH-1:0] event_clr_i,
    input  logic [WIDTH-1:0] irq_mask_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] event_o,
    output logic             irq_o,
    output logic             tick_o
);

    localparam int unsigned    PcW    = $clog2(TICK_DIV);
    localparam logic [PcW-1:0] PcLast = PcW'(TICK_DIV - 1);

    logic [PcW-1:0] pc_q, pc_d;

    // Prescaler wraps at TICK_DIV-1; the terminal count is the sample tick
    always_comb begin
        tick_o = (pc_q == PcLast);
        pc_d   = tick_o ? '0 : pc_q + PcW'(1);
    end

    // Prescaler register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .RESET_LEVEL  (RESET_LEVEL[i])
        ) u_chan (
            .clk_i       (clock),
            .rst_ni      (reset_n),
            .pad_i       (pad_i[i]),
            .tick_i      (tick_o),
            .event_clr_i (event_clr_i[i]),
            .level_o     (level_o[i]),
            .rise_o      (rise_o[i]),
            .fall_o      (fall_o[i]),
            .event_o     (event_o[i])
        );
    end

    // Interrupt is decoded straight from the event flags
    always_comb begin
        irq_o = |(event_o & irq_mask_i);
    end

endmodule

// File: tb/tb_gpio_key_debounce.sv
// Randomised bench for gpio_key_debounce against a sample-history reference model.
module tb_gpio_key_debounce;

    localparam int unsigned W  = 2;
    localparam int unsigned TD = 4;
    localparam int unsigned ST = 3;
    localparam logic [W-1:0] RL = 2'b11;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] pad_i = RL;
    logic [W-1:0] event_clr_i = '0;
    logic [W-1:0] irq_mask_i = '0;
    logic [W-1:0] level_o, rise_o, fall_o, event_o;
    logic         irq_o, tick_o;

    gpio_key_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST),
        .RESET_LEVEL  (RL)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .pad_i       (pad_i),
        .event_clr_i (event_clr_i),
        .irq_mask_i  (irq_mask_i),
        .level_o     (level_o),
        .rise_o      (rise_o),
        .fall_o      (fall_o),
        .event_o     (event_o),
        .irq_o       (irq_o),
        .tick_o      (tick_o)
    );

    always #5 clock = ~clock;

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: edges since release, pad history, and the tick-sample history
    int unsigned  ecnt;
    logic [W-1:0] pad_hist[$];
    logic [W-1:0] samp_hist[$];
    logic [W-1:0] m_level, m_rise, m_fall, m_event;

    task automatic model_reset();
        ecnt = 0;
        pad_hist.delete();
        samp_hist.delete();
        m_level = RL;
        m_rise  = '0;
        m_fall  = '0;
        m_event = '0;
    endtask

    // One rising edge: the sample seen is the pad from two edges back; a level is
    // accepted when the last ST tick samples all differ from the current level.
    task automatic model_edge(input logic [W-1:0] pad, input logic [W-1:0] clr);
        logic [W-1:0] s;
        logic         all_diff;
        ecnt++;
        m_event = (m_event & ~clr) | m_rise | m_fall;
        m_rise  = '0;
        m_fall  = '0;
        s = (pad_hist.size() >= 2) ? pad_hist[pad_hist.size() - 2] : RL;
        pad_hist.push_back(pad);
        if (pad_hist.size() > 4) void'(pad_hist.pop_front());
        if (ecnt % TD == 0) begin
            samp_hist.push_back(s);
            if (samp_hist.size() > ST) void'(samp_hist.pop_front());
            for (int i = 0; i < int'(W); i++) begin
                if (samp_hist.size() == ST) begin
                    all_diff = 1'b1;
                    for (int j = 0; j < int'(ST); j++) begin
                        if (samp_hist[j][i] == m_level[i]) all_diff = 1'b0;
                    end
                    if (all_diff) begin
                        m_level[i] = s[i];
                        if (s[i]) m_rise[i] = 1'b1;
                        else      m_fall[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("level", 32'(level_o), 32'(m_level));
        check("rise", 32'(rise_o), 32'(m_rise));
        check("fall", 32'(fall_o), 32'(m_fall));
        check("event", 32'(event_o), 32'(m_event));
        check("irq", 32'(irq_o), 32'(|(m_event & irq_mask_i)));
        check("tick", 32'(tick_o), 32'(ecnt % TD == TD - 1));
    endtask

    // Asynchronous reset pulse taken between clock edges
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat ($urandom_range(3, 1)) @(posedge clock);
        #1;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
    endtask

    int unsigned tg_tab[6] = '{4, 10, 16, 30, 12, 8};
    int unsigned cp_tab[6] = '{8, 8, 2, 16, 4, 30};

    initial begin
        model_reset();
        #12;
        check_outputs();
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();

        for (int ph = 0; ph < 6; ph++) begin
            for (int cyc = 0; cyc < 600; cyc++) begin
                // Phase 4 moves both pads together to exercise simultaneous acceptance
                if (ph == 4) begin
                    if ($urandom_range(tg_tab[ph] - 1) == 0) pad_i = ~pad_i;
                end else begin
                    for (int i = 0; i < int'(W); i++) begin
                        if ($urandom_range(tg_tab[ph] - 1) == 0) pad_i[i] = ~pad_i[i];
                    end
                end
                for (int i = 0; i < int'(W); i++) begin
                    event_clr_i[i] = ($urandom_range(cp_tab[ph] - 1) == 0);
                end
                if (cyc % 16 == 0) irq_mask_i = W'($urandom);
                @(posedge clock);
                model_edge(pad_i, event_clr_i);
                #1;
                check_outputs();
                if ($urandom_range(299) == 0) do_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
